// File: rtl/imm_decode_stage.sv
// RV32/RV64 immediate decode stage: classifies the opcode, builds the extended
// immediate and branch/jump target, and registers the result behind a skid buffer.
module imm_decode_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_target,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  logic [6:0]      opc;
  logic [2:0]      funct3;
  logic            is_shift;
  logic [5:0]      shamt_op;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_target;

  assign opc      = in_inst[6:0];
  assign funct3   = in_inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  // OP-IMM shifts carry a 6-bit shamt only on RV64; bit 25 belongs to funct7 on RV32
  assign shamt_op = (XLEN == 64) ? in_inst[25:20] : {1'b0, in_inst[24:20]};

  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));

  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FMT_ILL;
    dec_illegal = 1'b1;
    case (opc)
      7'b0000011, 7'b1100111: begin
        dec_imm = imm_i; dec_fmt = FMT_I; dec_illegal = 1'b0;
      end
      7'b0010011: begin
        dec_imm = is_shift ? XLEN'(shamt_op) : imm_i;
        dec_fmt = FMT_I; dec_illegal = 1'b0;
      end
      7'b0011011: begin
        dec_imm = is_shift ? XLEN'(in_inst[24:20]) : imm_i;
        dec_fmt = FMT_I; dec_illegal = 1'b0;
      end
      7'b0100011: begin
        dec_imm = imm_s; dec_fmt = FMT_S; dec_illegal = 1'b0;
      end
      7'b1100011: begin
        dec_imm = imm_b; dec_fmt = FMT_B; dec_illegal = 1'b0;
      end
      7'b0110111, 7'b0010111: begin
        dec_imm = imm_u; dec_fmt = FMT_U; dec_illegal = 1'b0;
      end
      7'b1101111: begin
        dec_imm = imm_j; dec_fmt = FMT_J; dec_illegal = 1'b0;
      end
      7'b0110011, 7'b0111011: begin
        dec_fmt = FMT_R; dec_illegal = 1'b0;
      end
      default: ;
    endcase
  end

  assign dec_target = in_pc + dec_imm;

  // Output register and skid buffer state
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic [2:0]       out_fmt_q, out_fmt_d;
  logic [XLEN-1:0]  out_target_q, out_target_d;
  logic             out_illegal_q, out_illegal_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
  logic [2:0]       skid_fmt_q, skid_fmt_d;
  logic [XLEN-1:0]  skid_target_q, skid_target_d;
  logic             skid_illegal_q, skid_illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_fire;

  assign in_ready = ~skid_valid_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_imm_d      = out_imm_q;
    out_fmt_d      = out_fmt_q;
    out_target_d   = out_target_q;
    out_illegal_d  = out_illegal_q;
    skid_valid_d   = skid_valid_q;
    skid_imm_d     = skid_imm_q;
    skid_fmt_d     = skid_fmt_q;
    skid_target_d  = skid_target_q;
    skid_illegal_d = skid_illegal_q;
    cnt_d          = cnt_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (out_fire && out_illegal_q && !(&cnt_q))
        cnt_d = cnt_q + 1'b1;
      if (!out_valid_q || out_ready) begin
        // Output slot frees this edge: older skid entry wins over a new input
        if (skid_valid_q) begin
          out_valid_d   = 1'b1;
          out_imm_d     = skid_imm_q;
          out_fmt_d     = skid_fmt_q;
          out_target_d  = skid_target_q;
          out_illegal_d = skid_illegal_q;
          skid_valid_d  = 1'b0;
        end else if (in_valid) begin
          out_valid_d   = 1'b1;
          out_imm_d     = dec_imm;
          out_fmt_d     = dec_fmt;
          out_target_d  = dec_target;
          out_illegal_d = dec_illegal;
        end else begin
          out_valid_d   = 1'b0;
        end
      end else if (in_valid && !skid_valid_q) begin
        skid_valid_d   = 1'b1;
        skid_imm_d     = dec_imm;
        skid_fmt_d     = dec_fmt;
        skid_target_d  = dec_target;
        skid_illegal_d = dec_illegal;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q    <= 1'b0;
      out_imm_q      <= '0;
      out_fmt_q      <= '0;
      out_target_q   <= '0;
      out_illegal_q  <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_imm_q     <= '0;
      skid_fmt_q     <= '0;
      skid_target_q  <= '0;
      skid_illegal_q <= 1'b0;
      cnt_q          <= '0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_imm_q      <= out_imm_d;
      out_fmt_q      <= out_fmt_d;
      out_target_q   <= out_target_d;
      out_illegal_q  <= out_illegal_d;
      skid_valid_q   <= skid_valid_d;
      skid_imm_q     <= skid_imm_d;
      skid_fmt_q     <= skid_fmt_d;
      skid_target_q  <= skid_target_d;
      skid_illegal_q <= skid_illegal_d;
      cnt_q          <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_target  = out_target_q;
  assign out_illegal = out_illegal_q;
  assign illegal_cnt = cnt_q;

endmodule
